// File: rtl/i2c_reg_master_if.sv
// i2c_reg_master_if: request/response handshake and SCL of the I2C register master.
interface i2c_reg_master_if;
    logic [7:0] i2c_slave, i2c_reg_addr, i2c_wdata, i2c_rdata;
    logic i2c_write_req, i2c_read_req, i2c_as_sccb;
    logic i2c_ready, i2c_rdata_valid, i2c_fail, i2c_wait_ack, i2c_sck;
    modport master (
        input  i2c_slave, i2c_reg_addr, i2c_wdata, i2c_write_req, i2c_read_req, i2c_as_sccb,
        output i2c_ready, i2c_rdata, i2c_rdata_valid, i2c_fail, i2c_wait_ack, i2c_sck
    );
    modport slave (
        output i2c_slave, i2c_reg_addr, i2c_wdata, i2c_write_req, i2c_read_req, i2c_as_sccb,
        input  i2c_ready, i2c_rdata, i2c_rdata_valid, i2c_fail, i2c_wait_ack, i2c_sck
    );
endinterface

// File: rtl/i2c_reg_master.sv
// i2c_reg_master: single-register I2C/SCCB write/read master built on 4-quarter bit slots.
module i2c_reg_master #(
    parameter int CLK_DIV = 25
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    i2c_reg_master_if.master bus,
    inout  wire              i2c_sda
);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, TXBYTE = 3'd2, ACK = 3'd3,
                           RSTART = 3'd4, RXBYTE = 3'd5, MNACK = 3'd6, STOP = 3'd7;
    localparam int DW = $clog2(CLK_DIV + 1);

    logic [2:0] state, bc;
    logic [DW-1:0] div;
    logic [1:0] q, bn;
    logic [7:0] sh, rx, reg_r, wdata_r;
    logic [6:0] addr_r;
    logic rd, sccb, nack, abort, sda_oe, sck_c, oe_c, tick, slot_end, sample;

    assign tick = state != IDLE && div == DW'(CLK_DIV - 1);
    assign slot_end = tick && q == 2'd3;
    assign sample = tick && q == 2'd1;
    assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

    // Line levels for the current quarter; registered below so SCL/SDA never glitch.
    always_comb begin
        sck_c = (state == IDLE || state == START) ? 1'b1 :
                (state == RSTART || state == STOP) ? q != 2'd0 : q[1];
        oe_c = (state == START || state == RSTART) ? q[1] :
               state == STOP ? ~q[1] : state == TXBYTE ? ~sh[7] : 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
            div <= '0;
            q <= '0;
            bc <= '0;
            bn <= '0;
            sh <= '0;
            rx <= '0;
            addr_r <= '0;
            reg_r <= '0;
            wdata_r <= '0;
            rd <= 1'b0;
            sccb <= 1'b0;
            nack <= 1'b0;
            abort <= 1'b0;
            sda_oe <= 1'b0;
            bus.i2c_sck <= 1'b1;
            bus.i2c_ready <= 1'b1;
            bus.i2c_rdata <= '0;
            bus.i2c_rdata_valid <= 1'b0;
            bus.i2c_fail <= 1'b0;
            bus.i2c_wait_ack <= 1'b0;
        end else begin
            bus.i2c_sck <= sck_c;
            sda_oe <= oe_c;
            bus.i2c_wait_ack <= state == ACK;
            bus.i2c_rdata_valid <= 1'b0;
            bus.i2c_fail <= 1'b0;
            div <= (state == IDLE || tick) ? '0 : div + DW'(1);
            if (state == IDLE) begin
                if (bus.i2c_write_req || bus.i2c_read_req) begin
                    state <= START;
                    q <= '0;
                    rd <= ~bus.i2c_write_req;
                    sccb <= bus.i2c_as_sccb;
                    addr_r <= bus.i2c_slave[7:1];
                    reg_r <= bus.i2c_reg_addr;
                    wdata_r <= bus.i2c_wdata;
                    abort <= 1'b0;
                    bus.i2c_ready <= 1'b0;
                end
            end else if (tick) begin
                q <= q + 2'd1;
                if (sample) nack <= ~sccb & i2c_sda;
                if (sample && state == RXBYTE) rx <= {rx[6:0], i2c_sda};
                if (slot_end) begin
                    case (state)
                        START: begin
                            state <= TXBYTE;
                            sh <= {addr_r, 1'b0};
                            bc <= '0;
                            bn <= 2'd0;
                        end
                        RSTART: begin
                            state <= TXBYTE;
                            sh <= {addr_r, 1'b1};
                            bc <= '0;
                            bn <= 2'd2;
                        end
                        TXBYTE: begin
                            sh <= {sh[6:0], 1'b0};
                            bc <= bc + 3'd1;
                            if (bc == 3'd7) state <= ACK;
                        end
                        ACK: begin
                            if (nack) begin
                                state <= STOP;
                                abort <= 1'b1;
                            end else if (bn == 2'd0) begin
                                state <= TXBYTE;
                                sh <= reg_r;
                                bn <= 2'd1;
                            end else if (bn == 2'd1) begin
                                state <= rd ? RSTART : TXBYTE;
                                sh <= wdata_r;
                                bn <= 2'd2;
                            end else begin
                                state <= rd ? RXBYTE : STOP;
                            end
                        end
                        RXBYTE: begin
                            bc <= bc + 3'd1;
                            if (bc == 3'd7) state <= MNACK;
                        end
                        MNACK: state <= STOP;
                        STOP: begin
                            state <= IDLE;
                            bus.i2c_ready <= 1'b1;
                            bus.i2c_fail <= abort;
                            if (rd && !abort) begin
                                bus.i2c_rdata <= rx;
                                bus.i2c_rdata_valid <= 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: doc/i2c_reg_master.md
I2C_REG_MASTER -- requirements
Module: i2c_reg_master

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 25, meaning sys_clk cycles per quarter SCL bit period (100 kHz SCL at 10 MHz).
REQ-002 The block SHALL have port sys_clk, input, 1, sole clock.
REQ-003 The block SHALL have port sys_rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port i2c_slave, input, 8, 7-bit device address in [7:1]; bit 0 is ignored.
REQ-005 The block SHALL have port i2c_reg_addr, input, 8, register address.
REQ-006 The block SHALL have port i2c_wdata, input, 8, write data byte.
REQ-007 The block SHALL have port i2c_write_req, input, 1, write request pulse.
REQ-008 The block SHALL have port i2c_read_req, input, 1, read request pulse.
REQ-009 The block SHALL have port i2c_as_sccb, input, 1, SCCB mode: ACK slots are not checked.
REQ-010 The block SHALL have port i2c_ready, output, 1, idle and able to accept a request.
REQ-011 The block SHALL have port i2c_rdata, output, 8, last byte read.
REQ-012 The block SHALL have port i2c_rdata_valid, output, 1, one-cycle pulse when i2c_rdata updates.
REQ-013 The block SHALL have port i2c_fail, output, 1, one-cycle pulse on NACK abort.
REQ-014 The block SHALL have port i2c_wait_ack, output, 1, high during each ACK slot.
REQ-015 The block SHALL have port i2c_sck, output, 1, SCL, push-pull.
REQ-016 The block SHALL have port i2c_sda, inout, 1, SDA, open-drain: drives 0 or Z, never 1.

Function
REQ-017 A quarter tick SHALL fire once every CLK_DIV sys_clk cycles while busy; the divider SHALL be cleared on request acceptance.
REQ-018 Each bit slot SHALL last 4 quarters: SCL low in Q0-Q1 and high in Q2-Q3; SDA SHALL change only at the Q0 start and SHALL be sampled at the Q2 start.
REQ-019 START SHALL be one slot: SDA released with SCL high, SDA low at Q2 with SCL high, SCL low at Q3 end.
REQ-020 STOP SHALL be one slot: SDA low and SCL low, then SCL high at Q1, then SDA released at Q2.
REQ-021 A request SHALL be accepted only when i2c_ready=1; requests while busy SHALL be ignored.
REQ-022 If i2c_write_req and i2c_read_req are both high in the same cycle, write SHALL win.
REQ-023 On acceptance, i2c_slave, i2c_reg_addr, i2c_wdata and the mode SHALL be latched, and i2c_ready SHALL drop on the next cycle.
REQ-024 The write sequence SHALL be: START, addr+W, ACK, reg, ACK, wdata, ACK, STOP (29 slots).
REQ-025 The read sequence SHALL be: START, addr+W, ACK, reg, ACK, repeated START, addr+R, ACK, 8 data bits (SDA released), master NACK (SDA released), STOP (39 slots).
REQ-026 Data SHALL be sent MSB first.
REQ-027 i2c_ready SHALL reassert exactly 116*CLK_DIV cycles after acceptance for a write and 156*CLK_DIV cycles for a read, ±1 cycle.
REQ-028 The FSM states SHALL be IDLE, START, TXBYTE, ACK, RSTART, RXBYTE, MNACK, STOP.
REQ-029 In ACK, SDA SHALL be released; when i2c_as_sccb=0, SDA=1 sampled at Q2 SHALL be a NACK.
REQ-030 On NACK the block SHALL skip the remaining bytes, go to STOP, pulse i2c_fail for one cycle when the STOP completes, then return to IDLE.
REQ-031 When i2c_as_sccb=1, no NACK SHALL be detected and i2c_fail SHALL never pulse.
REQ-032 i2c_rdata SHALL update and i2c_rdata_valid SHALL pulse for one cycle when a read's STOP completes; no update or pulse SHALL occur on a failed read.
REQ-033 i2c_wait_ack SHALL be high throughout every slave ACK slot and low otherwise.

Reset
REQ-034 When sys_rst=1 at a clock edge, the following SHALL take effect on that edge regardless of state, including mid-transaction (the aborted frame is not completed): state IDLE; i2c_sck=1; i2c_sda=Z; i2c_ready=1; i2c_rdata=0; i2c_rdata_valid=0; i2c_fail=0; i2c_wait_ack=0; divider and bit counters cleared.

Verification
REQ-035 Scenario: CLK_DIV=4, write slave 0xBA, reg 0x0D, data 0x21, slave model ACKs -> SDA bytes 0xBA, 0x0D, 0x21 seen on SCL rising edges; ready returns after 464±1 cycles; i2c_fail=0.
REQ-036 Scenario: read slave 0xBA, reg 0x00, model returns 0x15 -> repeated START observed, then 0xBB sent, then master NACK; i2c_rdata=0x15 with a one-cycle valid pulse; ready returns after 624±1 cycles.
REQ-037 Scenario: write with the model NACKing the reg byte and i2c_as_sccb=0 -> data byte not sent; STOP issued; i2c_fail pulses once; ready returns.
REQ-038 Scenario: same NACK with i2c_as_sccb=1 -> full 29-slot frame sent; no fail pulse.
REQ-039 Scenario: write and read requests in the same cycle, plus a second request while busy -> a single write frame only; the busy-time request is ignored.
REQ-040 Scenario: sys_rst asserted mid data byte -> next cycle i2c_sck=1, SDA=Z, ready=1; a following write completes normally.
